// File: rtl/start_sequencer.sv
// Multi-stage start sequencer: raises NUM_STAGES thermometer enables in order,
// each after its own programmable delay, with hold and restart control.
module start_sequencer #(
    parameter int unsigned                  NUM_STAGES = 4,
    parameter int unsigned                  CNT_W      = 20,
    parameter logic [NUM_STAGES*CNT_W-1:0]  DELAY_LIST = {NUM_STAGES{CNT_W'(25000)}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic                  restart,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic [NUM_STAGES-1:0] stage_pulse,
    output logic [3:0]            stage_idx,
    output logic                  busy,
    output logic                  starting
);

    typedef enum logic {
        S_RUN,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [3:0]              idx_q, idx_d;
    logic [NUM_STAGES-1:0]   en_q, en_d;
    logic [NUM_STAGES-1:0]   pulse_q, pulse_d;
    logic                    busy_q, busy_d;
    logic                    starting_q, starting_d;

    logic [CNT_W-1:0]        dly;
    logic [CNT_W-1:0]        cnt_inc;

    // Delay of the stage being timed; a programmed zero still costs one cycle.
    always_comb begin
        dly = '0;
        for (int unsigned k = 0; k < NUM_STAGES; k++) begin
            if (idx_q == 4'(k)) begin
                dly = DELAY_LIST[k*CNT_W +: CNT_W];
            end
        end
        if (dly == '0) begin
            dly = CNT_W'(1);
        end
    end

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        en_d       = en_q;
        pulse_d    = '0;
        busy_d     = busy_q;
        starting_d = starting_q;

        if (restart) begin
            state_d    = S_RUN;
            cnt_d      = '0;
            idx_d      = '0;
            en_d       = '0;
            busy_d     = 1'b1;
            starting_d = 1'b0;
        end else if (state_q == S_RUN && !hold) begin
            cnt_d = cnt_inc;
            if (cnt_inc == dly) begin
                cnt_d = '0;
                for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                    if (idx_q == 4'(k)) begin
                        en_d[k]    = 1'b1;
                        pulse_d[k] = 1'b1;
                    end
                end
                if (idx_q == 4'(NUM_STAGES - 1)) begin
                    state_d    = S_DONE;
                    starting_d = 1'b1;
                    busy_d     = 1'b0;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RUN;
            cnt_q      <= '0;
            idx_q      <= '0;
            en_q       <= '0;
            pulse_q    <= '0;
            busy_q     <= 1'b1;
            starting_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            en_q       <= en_d;
            pulse_q    <= pulse_d;
            busy_q     <= busy_d;
            starting_q <= starting_d;
        end
    end

    assign stage_en    = en_q;
    assign stage_pulse = pulse_q;
    assign stage_idx   = idx_q;
    assign busy        = busy_q;
    assign starting    = starting_q;

endmodule

// File: tb/tb_start_sequencer.sv
// Bench for start_sequencer: two instances (D=1,3,2 and D=0,15,0) driven in lockstep,
// checked against a cumulative-rise-edge model through a scoreboard queue.
module tb_start_sequencer;

    typedef struct packed {
        logic [2:0] en;
        logic [2:0] pulse;
        logic [3:0] idx;
        logic       busy;
        logic       start;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hold = 1'b0;
    logic       restart = 1'b0;
    logic [2:0] en_a, pulse_a, en_b, pulse_b;
    logic [3:0] idx_a, idx_b;
    logic       busy_a, start_a, busy_b, start_b;

    int   n_vec = 0;
    int   n_err = 0;
    int   act   = 0;
    int   e     = 0;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    start_sequencer #(
        .NUM_STAGES (3),
        .CNT_W      (4),
        .DELAY_LIST ({4'd2, 4'd3, 4'd1})
    ) dut_a (
        .clk         (clk),
        .rst         (rst),
        .hold        (hold),
        .restart     (restart),
        .stage_en    (en_a),
        .stage_pulse (pulse_a),
        .stage_idx   (idx_a),
        .busy        (busy_a),
        .starting    (start_a)
    );

    start_sequencer #(
        .NUM_STAGES (3),
        .CNT_W      (4),
        .DELAY_LIST ({4'd0, 4'd15, 4'd0})
    ) dut_b (
        .clk         (clk),
        .rst         (rst),
        .hold        (hold),
        .restart     (restart),
        .stage_en    (en_b),
        .stage_pulse (pulse_b),
        .stage_idx   (idx_b),
        .busy        (busy_b),
        .starting    (start_b)
    );

    // Stage k is up once the number of counting edges reaches its cumulative delay c[k].
    function automatic exp_t predict(int a, bit adv, int c0, int c1, int c2);
        exp_t p;
        int   c[3];
        int   n_up;
        c    = '{c0, c1, c2};
        n_up = 0;
        p    = '0;
        for (int k = 0; k < 3; k++) begin
            if (a >= c[k]) n_up++;
            if (adv && a == c[k]) p.pulse[k] = 1'b1;
        end
        p.en    = 3'((1 << n_up) - 1);
        p.idx   = (n_up >= 3) ? 4'd2 : 4'(n_up);
        p.busy  = (n_up < 3);
        p.start = (n_up == 3);
        return p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, e);
        end
    endtask

    task automatic step(input bit r, input bit h, input bit s);
        bit   adv;
        exp_t ea, eb;
        rst     = r;
        hold    = h;
        restart = s;
        adv     = 1'b0;
        if (r || s) act = 0;
        else if (!h) begin
            act++;
            adv = 1'b1;
        end
        qa.push_back(predict(act, adv, 1, 4, 6));
        qb.push_back(predict(act, adv, 1, 16, 17));
        if (r) e = 0;
        else e++;
        @(posedge clk);
        #1;
        ea = qa.pop_front();
        eb = qb.pop_front();
        chk("a_en", 32'(en_a), 32'(ea.en));
        chk("a_pulse", 32'(pulse_a), 32'(ea.pulse));
        chk("a_idx", 32'(idx_a), 32'(ea.idx));
        chk("a_busy", 32'(busy_a), 32'(ea.busy));
        chk("a_start", 32'(start_a), 32'(ea.start));
        chk("b_en", 32'(en_b), 32'(eb.en));
        chk("b_pulse", 32'(pulse_b), 32'(eb.pulse));
        chk("b_start", 32'(start_b), 32'(eb.start));
    endtask

    initial begin
        // Free-running sequence after reset; instance b covers zero and max delays.
        step(1, 0, 0);
        step(1, 0, 0);
        chk("rst_en", 32'(en_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd1);
        for (int i = 0; i < 18; i++) begin
            step(0, 0, 0);
            if (e == 1) chk("t1_en_e1", 32'(en_a), 32'b001);
            if (e == 3) chk("t1_en_e3", 32'(en_a), 32'b001);
            if (e == 4) chk("t1_pulse_e4", 32'(pulse_a), 32'b010);
            if (e == 6) chk("t1_start_e6", 32'(start_a), 32'd1);
            if (e == 6) chk("t1_busy_e6", 32'(busy_a), 32'd0);
            if (e == 7) chk("t1_pulse_e7", 32'(pulse_a), 32'b000);
            if (e == 15) chk("t6_en_e15", 32'(en_b), 32'b001);
            if (e == 16) chk("t6_en_e16", 32'(en_b), 32'b011);
            if (e == 17) chk("t6_en_e17", 32'(en_b), 32'b111);
        end

        // Hold on edges 2-4, then restart from S_DONE on edge 10.
        step(1, 0, 0);
        for (int i = 1; i <= 16; i++) begin
            step(0, (i >= 2 && i <= 4), (i == 10));
            if (e == 6) chk("t2_en_e6", 32'(en_a), 32'b001);
            if (e == 7) chk("t2_en_e7", 32'(en_a), 32'b011);
            if (e == 9) chk("t2_en_e9", 32'(en_a), 32'b111);
            if (e == 10) chk("t3_en_e10", 32'(en_a), 32'b000);
            if (e == 10) chk("t3_busy_e10", 32'(busy_a), 32'd1);
            if (e == 11) chk("t3_en_e11", 32'(en_a), 32'b001);
            if (e == 14) chk("t3_en_e14", 32'(en_a), 32'b011);
            if (e == 16) chk("t3_en_e16", 32'(en_a), 32'b111);
        end

        // Restart together with hold mid-run, then rst for two cycles.
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 1, 1);
        chk("t4_en_e3", 32'(en_a), 32'b000);
        step(0, 0, 0);
        chk("t4_en_e4", 32'(en_a), 32'b001);
        step(1, 0, 0);
        step(1, 0, 0);
        chk("t5_idx_rst", 32'(idx_a), 32'd0);
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 0);
            if (e == 1) chk("t5_en_e1", 32'(en_a), 32'b001);
            if (e == 4) chk("t5_en_e4", 32'(en_a), 32'b011);
            if (e == 7) chk("t5_idx_done", 32'(idx_a), 32'd2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
